counter_enable: RTL and testbench



---
 rtl/counter_enable_if.sv | 27 ++
 rtl/counter_enable.sv | 59 +++++
 tb/tb_counter_enable.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/counter_enable_if.sv
// Control and status bundle for the gated up-counter.
// The block side takes the slave modport; the stimulus side takes the master modport.
interface counter_enable_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic         pause;
  logic         active;
  logic         enable;
  logic [N-1:0] counter;

  modport slave (
    input  start,
    input  pause,
    output active,
    output enable,
    output counter
  );

  modport master (
    output start,
    output pause,
    input  active,
    input  enable,
    input  counter
  );
endinterface

// File: rtl/counter_enable.sv
// Gated up-counter with a start-armed run flag and a combinational pause gate.
// Only reset disarms the block; the count wraps silently modulo 2**N.
module counter_enable #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             reset,
  counter_enable_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] counter_q, counter_d;
  logic         enable_c;

  // State and count registers; reset clears both immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Run-flag transitions and count gating
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    enable_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // pause gates the current edge only; the run flag is untouched
        enable_c = ~bus.pause;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enable_c) begin
      counter_d = counter_q + N'(1);
    end
  end

  assign bus.active  = (state_q == ST_RUN);
  assign bus.enable  = enable_c;
  assign bus.counter = counter_q;

endmodule

// File: tb/tb_counter_enable.sv
// Directed bench for counter_enable: a bench-side model of run flag and count
// is checked every cycle, with literal expectations pinning the key points.
module tb_counter_enable;
  localparam int unsigned N   = 4;
  localparam int          MOD = 1 << N;

  logic clk = 1'b0;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  int m_active;
  int m_count;

  counter_enable_if #(.N(N)) bus ();

  counter_enable #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".active"},  32'(bus.active),  32'(m_active));
    chk({tag, ".enable"},  32'(bus.enable),  32'((m_active != 0) && !bus.pause));
    chk({tag, ".counter"}, 32'(bus.counter), 32'(m_count));
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model on the rising edge
  task automatic step(input logic st, input logic ps);
    bus.start = st;
    bus.pause = ps;
    #1 model_check("pre");
    @(posedge clk);
    if (m_active != 0 && !ps) m_count = (m_count + 1) % MOD;
    if (st) m_active = 1;
    @(negedge clk);
    model_check("post");
  endtask

  // Hold reset across one rising edge with the given start/pause levels
  task automatic hold_reset(input logic st, input logic ps);
    reset     = 1'b1;
    bus.start = st;
    bus.pause = ps;
    #1;
    m_active = 0;
    m_count  = 0;
    model_check("rst_in");
    @(posedge clk);
    @(negedge clk);
    model_check("rst_hold");
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    m_active  = 0;
    m_count   = 0;
    @(negedge clk);

    // T1 power-up idle, pause ignored before start
    hold_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, (i % 3) == 0);
    chk("t1.active",  32'(bus.active),  32'd0);
    chk("t1.counter", 32'(bus.counter), 32'd0);

    // T2 start latency
    step(1'b1, 1'b0);
    chk("t2.active_after_start",  32'(bus.active),  32'd1);
    chk("t2.counter_after_start", 32'(bus.counter), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      chk("t2.counter_run", 32'(bus.counter), 32'(i + 1));
    end

    // T3 pause freezes exactly one edge
    step(1'b0, 1'b1);
    chk("t3.paused4", 32'(bus.counter), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("t3.reach8", 32'(bus.counter), 32'd8);
    step(1'b0, 1'b1);
    chk("t3.paused8", 32'(bus.counter), 32'd8);
    step(1'b0, 1'b0);
    chk("t3.resume9", 32'(bus.counter), 32'd9);

    // T6 repeated start while active does not disturb the count
    step(1'b1, 1'b0);
    chk("t6.restart", 32'(bus.counter), 32'd10);
    step(1'b1, 1'b1);
    chk("t6.restart_pause", 32'(bus.counter), 32'd10);

    // T4 wrap from 0 over 16 enabled edges
    hold_reset(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    chk("t4.top",  32'(bus.counter), 32'd15);
    step(1'b0, 1'b0);
    chk("t4.wrap", 32'(bus.counter), 32'd0);
    chk("t4.active_kept", 32'(bus.active), 32'd1);

    // T5 asynchronous reset mid-cycle at count 7
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    chk("t5.at7", 32'(bus.counter), 32'd7);
    #2 reset = 1'b1;
    #1;
    m_active = 0;
    m_count  = 0;
    chk("t5.async_counter", 32'(bus.counter), 32'd0);
    chk("t5.async_active",  32'(bus.active),  32'd0);
    model_check("t5.async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("t5.idle_after", 32'(bus.counter), 32'd0);
    step(1'b0, 1'b1);
    chk("t6.pause_inactive", 32'(bus.counter), 32'd0);

    // T6 reset wins over a simultaneous start
    hold_reset(1'b1, 1'b0);
    chk("t6.rst_start_active", 32'(bus.active), 32'd0);
    step(1'b0, 1'b0);
    chk("t6.still_idle", 32'(bus.active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
